// File: rtl/cordic_if.sv
// Handshake bundle for the iterative CORDIC engine: command channel in, result channel out.
// master = command source / result sink, slave = the engine.
interface cordic_if #(
    parameter int WIDTH   = 16,
    parameter int ANGLE_W = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      mode;
    logic signed [WIDTH-1:0]   x_in;
    logic signed [WIDTH-1:0]   y_in;
    logic        [ANGLE_W-1:0] z_in;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [WIDTH+1:0]   x_out;
    logic signed [WIDTH+1:0]   y_out;
    logic        [ANGLE_W-1:0] z_out;
    logic                      busy;

    modport master (
        output in_valid, mode, x_in, y_in, z_in, out_ready,
        input  in_ready, out_valid, x_out, y_out, z_out, busy
    );

    modport slave (
        input  in_valid, mode, x_in, y_in, z_in, out_ready,
        output in_ready, out_valid, x_out, y_out, z_out, busy
    );
endinterface

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine (rotation/vectoring) with full-circle quadrant folding.
// Define CORDIC_GAIN_COMP_EN to add a SCALE cycle that removes the CORDIC gain.
module cordic_iter #(
    parameter int WIDTH   = 16,
    parameter int ANGLE_W = 16,
    parameter int ITER    = 14
) (
    input  logic     clk,
    input  logic     reset,
    cordic_if.slave  bus
);
    localparam int W2 = WIDTH + 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FOLD  = 3'd1;
    localparam logic [2:0] S_ROT   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef CORDIC_GAIN_COMP_EN
    localparam logic [2:0] S_SCALE = 3'd3;
`endif

    localparam logic [ANGLE_W-1:0] HALF_TURN = {1'b1, {(ANGLE_W-1){1'b0}}};

    logic [2:0]            state;
    logic signed [W2-1:0]  x, y, x_sh, y_sh, x_next, y_next, xo, yo;
    logic [ANGLE_W-1:0]    z, z_next, zo, atan_i;
    logic [31:0]           atan_full;
    logic [4:0]            i;
    logic                  md;
    logic                  d_pos;

    // atan(2^-i) in units of 2^-32 turn; narrowed to the angle width below
    always_comb begin
        atan_full = 32'd0;
        case (i)
            5'd0:  atan_full = 32'd536870912;
            5'd1:  atan_full = 32'd316933406;
            5'd2:  atan_full = 32'd167458907;
            5'd3:  atan_full = 32'd85004756;
            5'd4:  atan_full = 32'd42667331;
            5'd5:  atan_full = 32'd21354465;
            5'd6:  atan_full = 32'd10679838;
            5'd7:  atan_full = 32'd5340245;
            5'd8:  atan_full = 32'd2670163;
            5'd9:  atan_full = 32'd1335087;
            5'd10: atan_full = 32'd667544;
            5'd11: atan_full = 32'd333772;
            5'd12: atan_full = 32'd166886;
            5'd13: atan_full = 32'd83443;
            5'd14: atan_full = 32'd41722;
            5'd15: atan_full = 32'd20861;
            5'd16: atan_full = 32'd10430;
            5'd17: atan_full = 32'd5215;
            5'd18: atan_full = 32'd2608;
            5'd19: atan_full = 32'd1304;
            5'd20: atan_full = 32'd652;
            5'd21: atan_full = 32'd326;
            5'd22: atan_full = 32'd163;
            5'd23: atan_full = 32'd81;
            default: atan_full = 32'd0;
        endcase
    end

    assign atan_i = ANGLE_W'(atan_full >> (32 - ANGLE_W));
    assign x_sh   = x >>> i;
    assign y_sh   = y >>> i;

    // d=+1 steers z toward zero in rotation, y toward zero in vectoring
    assign d_pos  = md ? y[W2-1] : ~z[ANGLE_W-1];
    assign x_next = d_pos ? (x - y_sh) : (x + y_sh);
    assign y_next = d_pos ? (y + x_sh) : (y - x_sh);
    assign z_next = d_pos ? (z - atan_i) : (z + atan_i);

`ifdef CORDIC_GAIN_COMP_EN
    localparam logic signed [17:0] KINV = 18'sd39797;
    logic signed [W2+17:0] x_prod, y_prod;
    logic signed [W2-1:0]  x_scaled, y_scaled;
    assign x_prod   = (W2+18)'(x) * (W2+18)'(KINV);
    assign y_prod   = (W2+18)'(y) * (W2+18)'(KINV);
    assign x_scaled = W2'(x_prod >>> 16);
    assign y_scaled = W2'(y_prod >>> 16);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            i     <= '0;
            md    <= 1'b0;
            xo    <= '0;
            yo    <= '0;
            zo    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        x     <= W2'(bus.x_in);
                        y     <= W2'(bus.y_in);
                        z     <= bus.z_in;
                        md    <= bus.mode;
                        i     <= '0;
                        state <= S_FOLD;
                    end
                end
                // pre-rotate by 180 degrees so the iterations only cover +/-90
                S_FOLD: begin
                    if (md) begin
                        z <= x[W2-1] ? HALF_TURN : '0;
                        if (x[W2-1]) begin
                            x <= -x;
                            y <= -y;
                        end
                    end else if (z[ANGLE_W-1] ^ z[ANGLE_W-2]) begin
                        x <= -x;
                        y <= -y;
                        z <= z + HALF_TURN;
                    end
                    state <= S_ROT;
                end
                S_ROT: begin
                    x <= x_next;
                    y <= y_next;
                    z <= z_next;
                    i <= i + 5'd1;
                    if (i == 5'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state <= S_SCALE;
`else
                        xo    <= x_next;
                        yo    <= y_next;
                        zo    <= z_next;
                        state <= S_DONE;
`endif
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                S_SCALE: begin
                    xo    <= x_scaled;
                    yo    <= y_scaled;
                    zo    <= z;
                    state <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (bus.out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = reset && (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.x_out     = xo;
    assign bus.y_out     = yo;
    assign bus.z_out     = zo;
endmodule

// File: tb/tb_cordic_iter.sv
// Scoreboard bench for cordic_iter: trig reference model, decoupled driver and monitor.
module tb_cordic_iter;
    localparam int WIDTH   = 16;
    localparam int ANGLE_W = 16;
    localparam int ITER    = 14;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT = ITER + 3;
`else
    localparam int LAT = ITER + 2;
`endif
    localparam real TWO_PI   = 6.283185307179586;
    localparam real FULL     = 65536.0;
    localparam real ZTOL_ROT = 4.0;
    localparam real ZTOL_VEC = 16.0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cordic_if #(.WIDTH(WIDTH), .ANGLE_W(ANGLE_W)) bus();

    cordic_iter #(.WIDTH(WIDTH), .ANGLE_W(ANGLE_W), .ITER(ITER)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  ready_mode = 1;
    real gain = 1.0;

    real q_ex[$], q_ey[$], q_ez[$], q_txy[$], q_tz[$];
    int  q_acc[$];

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input real act, input real expv, input real tol);
        real diff;
        total++;
        diff = act - expv;
        if (diff > tol || diff < -tol) begin
            bad++;
            $display("[TB] FAIL %s: got %0.2f want %0.2f tol %0.1f at cycle %0d", name, act, expv, tol, cyc);
        end
    endtask

    task automatic checkExact(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d at cycle %0d", name, act, expv, cyc);
        end
    endtask

    task automatic checkAngle(input string name, input real act, input real expv, input real tol);
        real diff;
        diff = act - expv;
        diff = diff - FULL * $floor((diff + FULL / 2.0) / FULL);
        checkOutput(name, expv + diff, expv, tol);
    endtask

    // Ideal result from trig: rotate by the angle, or report magnitude and phase
    task automatic pushModel(input bit m, input int x, input int y, input int z, input int acc);
        real th, mag, ang;
        mag = gain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        if (!m) begin
            th = real'(z) * TWO_PI / FULL;
            q_ex.push_back(gain * (real'(x) * $cos(th) - real'(y) * $sin(th)));
            q_ey.push_back(gain * (real'(x) * $sin(th) + real'(y) * $cos(th)));
            q_ez.push_back(0.0);
            q_tz.push_back(ZTOL_ROT);
        end else begin
            ang = $atan2(real'(y), real'(x)) / TWO_PI * FULL;
            if (ang < 0.0) ang = ang + FULL;
            q_ex.push_back(mag);
            q_ey.push_back(0.0);
            q_ez.push_back(ang);
            q_tz.push_back(ZTOL_VEC);
        end
        q_txy.push_back(8.0 + mag / 512.0);
        q_acc.push_back(acc);
    endtask

    task automatic flushModel();
        q_ex.delete(); q_ey.delete(); q_ez.delete();
        q_txy.delete(); q_tz.delete(); q_acc.delete();
    endtask

    // Called just after a rising edge; returns after the accepting edge
    task automatic applyStimulus(input bit m, input int x, input int y, input int z,
                                 input bit hold, output int acc);
        int n;
        bus.mode     = m;
        bus.x_in     = WIDTH'(x);
        bus.y_in     = WIDTH'(y);
        bus.z_in     = ANGLE_W'(z);
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        acc = -1;
        if (!bus.in_ready) begin
            total++; bad++;
            $display("[TB] FAIL accept_timeout: in_ready got 0 want 1 after %0d cycles", n);
        end else begin
            acc = cyc + 1;
            pushModel(m, x, y, z, acc);
        end
        @(posedge clk); #1;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (q_acc.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checkExact("drain_pending", q_acc.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial forever begin
        @(posedge clk); #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(1));
        endcase
    end

    // Monitor: latency on rising out_valid, hold stability, pop-and-compare on handshake
    logic prev_valid = 1'b0;
    bit   holding = 1'b0;
    int   hx, hy, hz;
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
            holding    = 1'b0;
        end else begin
            if (bus.out_valid && !prev_valid) begin
                if (q_acc.size() == 0) begin
                    total++; bad++;
                    $display("[TB] FAIL unexpected_output: out_valid got 1 want 0 at cycle %0d", cyc);
                end else
                    checkExact("latency", cyc + 1 - q_acc[0], LAT);
            end
            if (bus.out_valid) checkExact("in_ready_in_done", int'(bus.in_ready), 0);
            if (holding && bus.out_valid) begin
                checkExact("hold_x", int'(bus.x_out), hx);
                checkExact("hold_y", int'(bus.y_out), hy);
                checkExact("hold_z", int'(bus.z_out), hz);
            end
            holding = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                if (q_acc.size() != 0) begin
                    checkOutput("x_out", real'(int'(bus.x_out)), q_ex[0], q_txy[0]);
                    checkOutput("y_out", real'(int'(bus.y_out)), q_ey[0], q_txy[0]);
                    checkAngle("z_out", real'(int'(bus.z_out)), q_ez[0], q_tz[0]);
                    void'(q_ex.pop_front()); void'(q_ey.pop_front()); void'(q_ez.pop_front());
                    void'(q_txy.pop_front()); void'(q_tz.pop_front()); void'(q_acc.pop_front());
                end
            end else if (bus.out_valid) begin
                holding = 1'b1;
                hx = int'(bus.x_out);
                hy = int'(bus.y_out);
                hz = int'(bus.z_out);
            end
            prev_valid = bus.out_valid;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc, prev_acc, x, y, z, n;
        bit m, seen;
        int rot_z[5] = '{0, 8192, 16384, 32768, 49152};

`ifndef CORDIC_GAIN_COMP_EN
        for (int k = 0; k < ITER; k++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * k));
`endif
        bus.in_valid  = 1'b0;
        bus.mode      = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.z_in      = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b0;

        idle(2);
        checkExact("rst_out_valid", int'(bus.out_valid), 0);
        checkExact("rst_busy", int'(bus.busy), 0);
        checkExact("rst_in_ready", int'(bus.in_ready), 0);
        checkExact("rst_x_out", int'(bus.x_out), 0);
        checkExact("rst_y_out", int'(bus.y_out), 0);
        checkExact("rst_z_out", int'(bus.z_out), 0);
        reset = 1'b1;
        idle(1);
        checkExact("release_in_ready", int'(bus.in_ready), 1);

        $display("[TB] directed rotation and vectoring");
        foreach (rot_z[k]) begin
            applyStimulus(1'b0, 16384, 0, rot_z[k], 1'b0, acc);
            waitDrain();
        end
        applyStimulus(1'b1, 12000, 16000, 0, 1'b0, acc);
        waitDrain();
        applyStimulus(1'b1, -12000, 16000, 1234, 1'b0, acc);
        waitDrain();

        $display("[TB] output held with out_ready low");
        ready_mode = 0;
        applyStimulus(1'b0, 9000, -5000, 20000, 1'b0, acc);
        n = 0;
        while (!bus.out_valid && n < 100) begin idle(1); n++; end
        checkExact("hold_reached_done", int'(bus.out_valid), 1);
        idle(5);
        ready_mode = 1;
        waitDrain();

        $display("[TB] in_valid pulse while busy");
        applyStimulus(1'b0, 10000, 3000, 5000, 1'b0, acc);
        idle(3);
        bus.x_in = 16'sd123;
        bus.in_valid = 1'b1;
        repeat (2) begin
            checkExact("busy_in_ready", int'(bus.in_ready), 0);
            idle(1);
        end
        bus.in_valid = 1'b0;
        waitDrain();
        idle(LAT + 4);

        $display("[TB] reset during iterations");
        applyStimulus(1'b0, 16384, 0, 8192, 1'b0, acc);
        idle(6);
        reset = 1'b0;
        flushModel();
        idle(1);
        reset = 1'b1;
        seen = 1'b0;
        repeat (LAT + 5) begin
            if (bus.out_valid) seen = 1'b1;
            idle(1);
        end
        checkExact("abort_no_output", int'(seen), 0);
        applyStimulus(1'b0, 16384, 0, 16384, 1'b0, acc);
        waitDrain();

        $display("[TB] back-to-back sweep");
        prev_acc = 0;
        for (int k = 0; k < 25; k++) begin
            z = $rtoi(real'(k) * FULL / 24.0 + 0.5) % 65536;
            applyStimulus(1'b0, 16384, 0, z, 1'b1, acc);
            if (k > 0) checkExact("throughput", acc - prev_acc, LAT + 1);
            prev_acc = acc;
        end
        bus.in_valid = 1'b0;
        waitDrain();

        $display("[TB] randomized commands");
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            m = 1'($urandom_range(1));
            z = int'($urandom_range(65535));
            n = 0;
            do begin
                x = int'($urandom_range(42000)) - 21000;
                y = int'($urandom_range(42000)) - 21000;
                n++;
            end while (m && (x * x + y * y) < 64000000 && n < 100);
            if (m && (x * x + y * y) < 64000000) x = 15000;
            applyStimulus(m, x, y, z, 1'b0, acc);
            if ($urandom_range(3) == 0) idle(int'($urandom_range(4)));
        end
        waitDrain();
        ready_mode = 1;
        idle(LAT + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
